// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// parity modes and the expected-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  localparam int unsigned MAX_DATA_BITS = 8;

  // Expected parity bit: XOR of the data for even, XNOR for odd.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic [1:0]               mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one pulse every DIVISOR clocks, phase clearable.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_clr || (cnt_q == CNT_MAX)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_tick_c = !i_clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority voting, parity/framing checks,
// break detection and a single-entry valid/ready holding register.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter logic [1:0]  EN_PARITY  = 2'b00,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_uart_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_break
);

  localparam int unsigned DIVISOR = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned SCNT_W  = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] SMP_A    = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SMP_B    = SCNT_W'(OVERSAMPLE / 2);
  localparam logic [SCNT_W-1:0] SMP_C    = SCNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_ovs: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_ovs: STOP_BITS must be 1 or 2");
  end
  if (EN_PARITY == 2'b10) begin : g_bad_parity
    $error("uart_rx_ovs: EN_PARITY must be 00, 01 or 11");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_ovs: OVERSAMPLE must be even and at least 8");
  end
  if (DIVISOR == 0) begin : g_bad_divisor
    $error("uart_rx_ovs: clock too slow for BAUD_RATE*OVERSAMPLE");
  end

  logic [2:0]           sync_q, sync_d;
  logic                 rx_prev_q;
  state_e               state_q, state_d;
  logic [SCNT_W-1:0]    s_cnt_q, s_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 any_one_q, any_one_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 break_q, break_d;
  logic                 tick_c, tick_clr;
  logic                 rx_s, rx_fall, vote_en, maj, frame_done;

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (tick_clr),
    .o_tick_c (tick_c)
  );

  assign rx_s    = sync_q[2];
  assign rx_fall = rx_prev_q & ~rx_s;
  assign vote_en = tick_c && (s_cnt_q == SMP_C);
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  always_comb begin
    sync_d     = {sync_q[1:0], i_uart_rx};
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    smp_d      = smp_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    any_one_d  = any_one_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    overrun_d  = overrun_q;
    break_d    = 1'b0;
    tick_clr   = 1'b0;
    frame_done = 1'b0;

    // Bit-phase counter and the first two of the three majority samples
    if (tick_c && state_q != ST_IDLE && state_q != ST_BREAK_WAIT) begin
      s_cnt_d = (s_cnt_q == SCNT_MAX) ? '0 : s_cnt_q + SCNT_W'(1);
      if (s_cnt_q == SMP_A) smp_d[0] = rx_s;
      if (s_cnt_q == SMP_B) smp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          tick_clr = 1'b1;
          s_cnt_d  = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (vote_en) begin
          if (!maj) begin
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            any_one_d  = 1'b0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
            state_d    = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (vote_en) begin
          shift_d   = {maj, shift_q[DATA_BITS-1:1]};
          any_one_d = any_one_q | maj;
          if (bit_cnt_q == BIT_LAST)
            state_d = (EN_PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (vote_en) begin
          par_err_d = (maj != parity_bit(MAX_DATA_BITS'(shift_q), EN_PARITY));
          any_one_d = any_one_q | maj;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (vote_en) begin
          if (stop_cnt_q == 1'b0 && !maj && !any_one_q) begin
            break_d = 1'b1;
            state_d = ST_BREAK_WAIT;
          end else begin
            frm_err_d = frm_err_q | ~maj;
            if (stop_cnt_q == STOP_LAST) begin
              frame_done = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Holding register: a handshake frees it; a completed frame either
    // loads (free or being freed) or is dropped as an overrun.
    if (valid_q && i_data_ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (frame_done) begin
      if (!valid_q || i_data_ready) begin
        data_d  = shift_q;
        perr_d  = par_err_q;
        ferr_d  = frm_err_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      s_cnt_q    <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      any_one_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      any_one_q  <= any_one_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
      break_q    <= break_d;
    end
  end

  assign o_uart_data  = data_q;
  assign o_data_valid = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = overrun_q;
  assign o_break      = break_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: an 8N1 instance and a 7O2 instance at
// 115200 baud from 50 MHz with 16x oversampling (27 clocks per tick).
module tb_uart_rx_ovs;

  localparam int unsigned BIT_CYC = 27 * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx1 = 1'b1, ready1 = 1'b0;
  logic [7:0] d1;
  logic       v1, pe1, fe1, ovr1, brk1;
  logic       rx2 = 1'b1, ready2 = 1'b0;
  logic [6:0] d2;
  logic       v2, pe2, fe2, ovr2, brk2;

  uart_rx_ovs #(
    .CLOCK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8),
    .EN_PARITY(2'b00), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_uart_rx(rx1), .o_uart_data(d1),
    .o_data_valid(v1), .i_data_ready(ready1), .o_parity_err(pe1),
    .o_frame_err(fe1), .o_overrun(ovr1), .o_break(brk1)
  );

  uart_rx_ovs #(
    .CLOCK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(7),
    .EN_PARITY(2'b11), .STOP_BITS(2), .OVERSAMPLE(16)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .i_uart_rx(rx2), .o_uart_data(d2),
    .o_data_valid(v2), .i_data_ready(ready2), .o_parity_err(pe2),
    .o_frame_err(fe2), .o_overrun(ovr2), .o_break(brk2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Handshake / pulse recorders, sampled on the falling edge
  int         hs1 = 0, hs2 = 0, vcyc1 = 0, brk_cnt1 = 0;
  logic [7:0] ld1 = '0, ld2 = '0;
  logic       lpe1 = 0, lfe1 = 0, lpe2 = 0, lfe2 = 0;

  always @(negedge clk) begin
    if (v1 === 1'b1) vcyc1++;
    if (brk1 === 1'b1) brk_cnt1++;
    if (v1 === 1'b1 && ready1) begin
      hs1++; ld1 = d1; lpe1 = pe1; lfe1 = fe1;
    end
    if (v2 === 1'b1 && ready2) begin
      hs2++; ld2 = {1'b0, d2}; lpe2 = pe2; lfe2 = fe2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int line, input logic val);
    if (line == 1) rx1 = val;
    else           rx2 = val;
  endtask

  task automatic send_bit(input int line, input logic b, input logic spike);
    drive(line, b);
    step(BIT_CYC / 2);
    if (spike) begin
      drive(line, ~b);
      step(1);
      drive(line, b);
      step(BIT_CYC - BIT_CYC / 2 - 1);
    end else begin
      step(BIT_CYC - BIT_CYC / 2);
    end
  endtask

  // start, nbits LSB first, optional parity, nstop stop bits, one idle bit
  task automatic send_frame(input int line, input logic [7:0] data, input int nbits,
                            input logic has_par, input logic par,
                            input logic [1:0] stops, input int nstop, input int spike_idx);
    send_bit(line, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(line, data[i], i == spike_idx);
    if (has_par) send_bit(line, par, 1'b0);
    for (int i = 0; i < nstop; i++) send_bit(line, stops[i], 1'b0);
    drive(line, 1'b1);
    step(BIT_CYC);
  endtask

  int h, b, vc;

  initial begin
    step(5);
    check("rst_data1", d1, 0);
    check("rst_valid1", v1, 0);
    check("rst_perr1", pe1, 0);
    check("rst_ferr1", fe1, 0);
    check("rst_ovr1", ovr1, 0);
    check("rst_brk1", brk1, 0);
    check("rst_valid2", v2, 0);
    rst_n = 1'b1;
    step(5);

    // 8N1 0xA5 with ready high
    ready1 = 1'b1;
    h = hs1; vc = vcyc1;
    send_frame(1, 8'hA5, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    check("a5_hs", hs1, h + 1);
    check("a5_data", ld1, 8'hA5);
    check("a5_perr", lpe1, 0);
    check("a5_ferr", lfe1, 0);
    check("a5_valid_cycles", vcyc1 - vc, 1);
    check("a5_ovr", ovr1, 0);

    // 7O2 0x35 (four ones, odd parity bit = 1): bad parity, then bad 2nd stop
    ready2 = 1'b1;
    h = hs2;
    send_frame(2, 8'h35, 7, 1'b1, 1'b0, 2'b11, 2, -1);
    check("par_hs", hs2, h + 1);
    check("par_data", ld2, 8'h35);
    check("par_perr", lpe2, 1);
    check("par_ferr", lfe2, 0);
    send_frame(2, 8'h35, 7, 1'b1, 1'b1, 2'b01, 2, -1);
    check("stop2_hs", hs2, h + 2);
    check("stop2_data", ld2, 8'h35);
    check("stop2_perr", lpe2, 0);
    check("stop2_ferr", lfe2, 1);

    // 3-cycle glitch must not start a frame; 1-cycle spike mid data bit 2
    h = hs1;
    drive(1, 1'b0);
    step(3);
    drive(1, 1'b1);
    step(2 * BIT_CYC);
    check("glitch_hs", hs1, h);
    check("glitch_valid", v1, 0);
    send_frame(1, 8'h0F, 8, 1'b0, 1'b0, 2'b11, 1, 2);
    check("spike_hs", hs1, h + 1);
    check("spike_data", ld1, 8'h0F);
    check("spike_ferr", lfe1, 0);

    // overrun: 0x11 held, 0x22 dropped, then handshake clears overrun
    ready1 = 1'b0;
    h = hs1;
    send_frame(1, 8'h11, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    send_frame(1, 8'h22, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    check("ovr_valid", v1, 1);
    check("ovr_held", d1, 8'h11);
    check("ovr_flag", ovr1, 1);
    check("ovr_no_hs", hs1, h);
    ready1 = 1'b1;
    step(1);
    check("ovr_hs", hs1, h + 1);
    check("ovr_hs_data", ld1, 8'h11);
    check("ovr_valid_clr", v1, 0);
    check("ovr_clr", ovr1, 0);

    // break: 12 bit times low
    h = hs1; b = brk_cnt1;
    drive(1, 1'b0);
    step(12 * BIT_CYC);
    drive(1, 1'b1);
    step(BIT_CYC);
    check("brk_pulses", brk_cnt1, b + 1);
    check("brk_no_word", hs1, h);
    check("brk_valid", v1, 0);
    send_frame(1, 8'h5A, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    check("post_brk_hs", hs1, h + 1);
    check("post_brk_data", ld1, 8'h5A);

    // reset in the middle of 0xFF
    h = hs1; b = brk_cnt1;
    send_bit(1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1, 1'b1, 1'b0);
    check("pre_rst_data", d1, 8'h5A);
    rst_n = 1'b0;
    step(3);
    check("mid_rst_data", d1, 0);
    check("mid_rst_valid", v1, 0);
    check("mid_rst_ovr", ovr1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1, 1'b1, 1'b0);
    step(BIT_CYC);
    check("post_rst_no_word", hs1, h);
    check("post_rst_valid", v1, 0);
    check("post_rst_no_brk", brk_cnt1, b);
    send_frame(1, 8'h3C, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    check("rst_next_hs", hs1, h + 1);
    check("rst_next_data", ld1, 8'h3C);
    check("rst_next_ferr", lfe1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
